bus_hs_update_sampler: RTL

- Source-domain front end that sits directly upstream of the asynchronous bus handshake synchronizer. It receives a data word on every IN_VLD.
- It filters out unchanged values (optional) and coalesces updates that arrive while a crossing is in flight; only the newest value survives.
- It holds one word stable on HS_DATA and requests its transfer with HS_SEND/HS_READY.
- Status counters report sent and coalesced updates.

---
 rtl/bus_hs_update_sampler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bus_hs_update_sampler.sv
// bus_hs_update_sampler
//   Source-domain front end for the asynchronous bus handshake synchronizer.
//   Candidate words arriving on IN_VLD are optionally filtered against the
//   latest accepted value. They are parked in a one-deep shadow register
//   (SHD/PEND) and moved into the hold register when the handshake is idle.
//   A newer accepted word overwrites a pending one, and that overwrite is
//   counted as a coalesce.
//
// Ports
//   CLK, RST_N       source clock, asynchronous active-low reset
//   IN_DATA/IN_VLD   candidate word and its valid strobe
//   FORCE_SEND       with IN_VLD: accept the word even if it is unchanged
//   HS_DATA/HS_SEND  word and request presented to the synchronizer
//   HS_READY         synchronizer idle/accepting level
//   BUSY             transfer in flight or word pending
//   STAT_SENT        completed transfers (saturating)
//   STAT_COALESCED   accepted words overwritten before being sent (saturating)
//   STAT_CLR         synchronous clear of both counters; wins over increments
module bus_hs_update_sampler #(
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 16,
    parameter bit SEND_ON_CHANGE = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VLD,
    input  logic                  FORCE_SEND,
    output logic [DATA_WIDTH-1:0] HS_DATA,
    output logic                  HS_SEND,
    input  logic                  HS_READY,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  STAT_SENT,
    output logic [CNT_WIDTH-1:0]  STAT_COALESCED,
    input  logic                  STAT_CLR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_DROP,
        S_WAIT_RISE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [DATA_WIDTH-1:0]   shd_q, shd_d;
    logic                    pend_q, pend_d;
    logic                    hs_send_q, hs_send_d;
    logic                    busy_q, busy_d;
    logic [CNT_WIDTH-1:0]    sent_q, sent_d;
    logic [CNT_WIDTH-1:0]    coal_q, coal_d;

    logic [DATA_WIDTH-1:0]   ref_val;
    logic                    accept;
    logic                    consume;
    logic                    sent_inc;
    logic                    coal_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc,
        input logic                 clr
    );
        if (clr)
            return '0;
        else if (inc && (cnt != {CNT_WIDTH{1'b1}}))
            return cnt + CNT_WIDTH'(1);
        else
            return cnt;
    endfunction

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        shd_d    = shd_q;
        pend_d   = pend_q;
        sent_inc = 1'b0;

        // While a word is pending it is the newest accepted value; otherwise
        // the hold register is.
        ref_val = pend_q ? shd_q : hold_q;
        accept  = IN_VLD && (!SEND_ON_CHANGE || FORCE_SEND || (IN_DATA != ref_val));
        consume = (state_q == S_IDLE) && pend_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    hold_d  = shd_q;
                    pend_d  = 1'b0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (HS_READY) begin
                    sent_inc = 1'b1;
                    state_d  = S_WAIT_DROP;
                end
            end
            S_WAIT_DROP: begin
                if (!HS_READY)
                    state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (HS_READY)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A word accepted in the same cycle the pending word is consumed simply
        // becomes the next pending word; nothing was lost, so no coalesce.
        if (accept) begin
            shd_d  = IN_DATA;
            pend_d = 1'b1;
        end
        coal_inc = accept && pend_q && !consume;

        sent_d    = sat_inc(sent_q, sent_inc, STAT_CLR);
        coal_d    = sat_inc(coal_q, coal_inc, STAT_CLR);
        hs_send_d = (state_d == S_SEND);
        busy_d    = (state_d != S_IDLE) || pend_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            shd_q     <= '0;
            pend_q    <= 1'b0;
            hs_send_q <= 1'b0;
            busy_q    <= 1'b0;
            sent_q    <= '0;
            coal_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shd_q     <= shd_d;
            pend_q    <= pend_d;
            hs_send_q <= hs_send_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
            coal_q    <= coal_d;
        end
    end

    assign HS_DATA        = hold_q;
    assign HS_SEND        = hs_send_q;
    assign BUSY           = busy_q;
    assign STAT_SENT      = sent_q;
    assign STAT_COALESCED = coal_q;

endmodule
